// File: rtl/shift_seq_unit.sv
// Iterative MIPS shifter (SLL/SRL/SRA and variable forms): moves the operand one bit
// per clock, with valid/ready handshakes on both the request and the response side.
module shift_seq_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   input  logic [SHW-1:0]   req_shamt,
   input  logic             req_dir,
   input  logic             req_arith,
   output logic             busy,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [SHW-1:0] ONE = SHW'(1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   count;
   logic             dir;
   logic             arith;
   logic             fill;

   // Sign fill applies only to right shifts; left shifts always bring in a zero.
   assign fill = arith & work[WIDTH-1];

   // NOTE: every clocked process uses non-blocking assignments so all registers
   // update together from pre-edge values, matching the hardware.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (req_valid) state_next = (req_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (count == ONE) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // A flush freezes the datapath: the operand in flight stays where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         work  <= '0;
         count <= '0;
         dir   <= 1'b0;
         arith <= 1'b0;
      end else if (!flush) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  work  <= req_data;
                  count <= req_shamt;
                  dir   <= req_dir;
                  arith <= req_arith;
               end
            end
            SHIFT: begin
               if (dir) work <= {fill, work[WIDTH-1:1]};
               else     work <= {work[WIDTH-2:0], 1'b0};
               count <= count - ONE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state == SHIFT);
      rsp_valid = (state == DONE);
   end

   assign rsp_data = work;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: result values, latency, backpressure, flush and
// reset abort, each checked against hand-computed values.
module tb_shift_seq_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_data;
   logic [4:0]  req_shamt;
   logic        req_dir;
   logic        req_arith;
   logic        busy;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;

   int total = 0;
   int bad   = 0;

   shift_seq_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_shamt (req_shamt),
      .req_dir   (req_dir),
      .req_arith (req_arith),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Presents one request and steps through the accept edge; returns in the first cycle after accept.
   task automatic accept(input logic [31:0] d, input logic [4:0] s, input logic dr, input logic ar);
      int n = 0;
      while (!req_ready && n < 50) begin
         step;
         n++;
      end
      check("accept_ready", {31'd0, req_ready}, 32'd1);
      req_data  = d;
      req_shamt = s;
      req_dir   = dr;
      req_arith = ar;
      req_valid = 1'b1;
      step;
      req_valid = 1'b0;
   endtask

   // Cycles after accept until rsp_valid (lat) and how many of those had busy=1.
   task automatic wait_rsp(output int lat, output int busy_n);
      lat    = 1;
      busy_n = 0;
      while (!rsp_valid && lat < 40) begin
         if (busy) busy_n++;
         step;
         lat++;
      end
      check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic handshake;
      rsp_ready = 1'b1;
      step;
      rsp_ready = 1'b0;
      check("hs_req_ready", {31'd0, req_ready}, 32'd1);
      check("hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                         input logic dr, input logic ar, input logic [31:0] exp_data);
      int lat;
      int busy_n;
      accept(d, s, dr, ar);
      wait_rsp(lat, busy_n);
      check({tag, "_data"}, rsp_data, exp_data);
      check({tag, "_latency"}, lat, 32'(s) + 32'd1);
      check({tag, "_busy_cycles"}, busy_n, 32'(s));
      handshake;
   endtask

   initial begin
      int lat;
      int busy_n;
      logic [31:0] held;

      rst       = 1'b1;
      flush     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;   // must be ignored while rst is high
      req_data  = 32'hAAAA_5555;
      req_shamt = 5'd3;
      req_dir   = 1'b0;
      req_arith = 1'b0;
      step;
      step;
      rst       = 1'b0;
      req_valid = 1'b0;
      step;
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("reset_busy",      {31'd0, busy},      32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_data",  rsp_data,           32'h0000_0000);

      // Basic shifts
      run_op("sll4",      32'h0000_0001, 5'd4,  1'b0, 1'b0, 32'h0000_0010);
      run_op("sra31",     32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_op("srl31",     32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
      run_op("shamt0",    32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF);
      run_op("sra8_neg",  32'hF000_000F, 5'd8,  1'b1, 1'b1, 32'hFFF0_0000);
      run_op("srl8",      32'hF000_000F, 5'd8,  1'b1, 1'b0, 32'h00F0_0000);
      run_op("sra3_pos",  32'h7000_0000, 5'd3,  1'b1, 1'b1, 32'h0E00_0000);
      run_op("sll8_arith",32'hF000_000F, 5'd8,  1'b0, 1'b1, 32'h0000_0F00);

      // Backpressure: result held, no new request taken, including during the handshake cycle
      accept(32'h0000_0003, 5'd2, 1'b0, 1'b0);
      wait_rsp(lat, busy_n);
      held      = rsp_data;
      check("bp_data", held, 32'h0000_000C);
      req_valid = 1'b1;
      req_data  = 32'h1234_5678;
      req_shamt = 5'd1;
      for (int i = 0; i < 5; i++) begin
         step;
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_data",  rsp_data,           32'h0000_000C);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      step;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("bp_after_req_ready", {31'd0, req_ready}, 32'd1);
      check("bp_after_busy",      {31'd0, busy},      32'd0);
      check("bp_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      // Flush in the 3rd SHIFT cycle of a 10-bit shift: two shifts have happened
      accept(32'h0000_0001, 5'd10, 1'b0, 1'b0);
      step;
      step;
      check("flush_busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      step;
      flush = 1'b0;
      check("flush_req_ready", {31'd0, req_ready}, 32'd1);
      check("flush_busy",      {31'd0, busy},      32'd0);
      check("flush_work_kept", rsp_data,           32'h0000_0004);
      for (int i = 0; i < 12; i++) begin
         check("flush_no_rsp", {31'd0, rsp_valid}, 32'd0);
         step;
      end

      // Flush while holding a result drops it without a handshake
      accept(32'h0000_0005, 5'd1, 1'b0, 1'b0);
      wait_rsp(lat, busy_n);
      flush = 1'b1;
      step;
      flush = 1'b0;
      check("flush_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("flush_done_req_ready", {31'd0, req_ready}, 32'd1);

      // Reset in the 3rd SHIFT cycle, with flush also high (reset wins and clears work)
      accept(32'h0000_0001, 5'd10, 1'b0, 1'b0);
      step;
      step;
      rst   = 1'b1;
      flush = 1'b1;
      step;
      rst   = 1'b0;
      flush = 1'b0;
      check("rst_abort_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_abort_busy",      {31'd0, busy},      32'd0);
      check("rst_abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_abort_rsp_data",  rsp_data,           32'h0000_0000);

      // Unit still works after the abort
      run_op("post_abort", 32'h0000_0080, 5'd7, 1'b1, 1'b0, 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
